// File: rtl/multiword_add_sequencer.sv
// Sequential WIDTH-bit adder: one 4-bit ripple slice per clock, LSB first, carry chained in a register.
// Optional macro MULTIWORD_ADD_SIGNED_OVF_EN adds a registered two's-complement overflow output.
module multiword_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    output logic             overflow,
`endif
    output logic             cout
);

    localparam int NUM_SLICES = WIDTH / 4;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam int POS_W      = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [4:0] add_slice(input logic [3:0] x, input logic [3:0] y, input logic c);
        add_slice = {1'b0, x} + {1'b0, y} + {4'b0000, c};
    endfunction

    state_t             state_r;
    state_t             state_next_s;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [IDX_W-1:0]   idx_r;
    logic [WIDTH-1:0]   result_r;
    logic [WIDTH-1:0]   sum_r;
    logic               cout_r;
    logic               busy_r;
    logic               done_r;
    logic [POS_W-1:0]   pos_s;
    logic [4:0]         slice_s;
    logic [WIDTH-1:0]   result_next_s;
    logic               last_s;
    logic               top_cin_s;

    assign pos_s   = POS_W'({idx_r, 2'b00});
    assign slice_s = add_slice(a_r[pos_s +: 4], b_r[pos_s +: 4], carry_r);
    assign last_s  = (idx_r == IDX_W'(NUM_SLICES - 1));
    // Carry into the MSB recovered from the top slice's sum bit.
    assign top_cin_s = a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ slice_s[3];

    // Merge the current slice result into the partially built word.
    always_comb begin
        result_next_s = result_r;
        result_next_s[pos_s +: 4] = slice_s[3:0];
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_next_s = ST_DONE;
                else        state_next_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_next_s = ST_RUN;
                else       state_next_s = ST_IDLE;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register with registered status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s == ST_RUN);
            done_r  <= (state_next_s == ST_DONE);
        end
    end

    // Operand capture, slice sequencing and result load.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            carry_r  <= 1'b0;
            idx_r    <= '0;
            result_r <= '0;
            sum_r    <= '0;
            cout_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        a_r      <= a;
                        b_r      <= b;
                        carry_r  <= cin;
                        idx_r    <= '0;
                        result_r <= '0;
                    end
                end
                ST_RUN: begin
                    result_r <= result_next_s;
                    carry_r  <= slice_s[4];
                    if (last_s) begin
                        idx_r  <= '0;
                        sum_r  <= result_next_s;
                        cout_r <= slice_s[4];
                    end else begin
                        idx_r  <= idx_r + IDX_W'(1);
                    end
                end
                default: begin
                    idx_r <= '0;
                end
            endcase
        end
    end

`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    logic overflow_r;

    // Signed overflow captured with the final slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (state_r == ST_RUN && last_s) begin
            overflow_r <= top_cin_s ^ slice_s[4];
        end else begin
            overflow_r <= overflow_r;
        end
    end

    assign overflow = overflow_r;
`else
    logic unused_s;
    assign unused_s = top_cin_s;
`endif

    assign busy = busy_r;
    assign done = done_r;
    assign sum  = sum_r;
    assign cout = cout_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed self-checking bench for multiword_add_sequencer at WIDTH=16.
module tb_multiword_add_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
    logic        overflow;
`endif

    int tests_run;
    int tests_failed;

    multiword_add_sequencer #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
        .overflow (overflow),
`endif
        .cout     (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run = tests_run + 1;
        if (got !== exp) begin
            tests_failed = tests_failed + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts edges after the current point until done is seen; -1 on timeout.
    task automatic wait_done(output int n);
        int k;
        bit seen;
        n = -1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(posedge clk);
            #1;
            k = k + 1;
            if (done) begin
                seen = 1'b1;
                n = k;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tbv, input logic tc,
                          input logic [15:0] esum, input logic ecout, input logic eovf);
        int n;
        @(negedge clk);
        a = ta; b = tbv; cin = tc; start = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0; a = ~ta; b = ~tbv; cin = ~tc;
        wait_done(n);
        check({tag, "_lat"}, n, 32'd4);
        check({tag, "_sum"}, {16'd0, sum}, {16'd0, esum});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ecout});
`ifdef MULTIWORD_ADD_SIGNED_OVF_EN
        check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
`else
        if (eovf === 1'bx) $display("note: overflow not built");
`endif
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
        check({tag, "_hold"}, {16'd0, sum}, {16'd0, esum});
    endtask

    initial begin
        int n;
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_sum", {16'd0, sum}, 32'h0000);
        check("rst_cout", {31'd0, cout}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_done", {31'd0, done}, 32'd0);

        run_op("add5_3", 16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);
        run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run_op("cin_mix", 16'h1234, 16'h0FFF, 1'b1, 16'h2234, 1'b0, 1'b0);
        run_op("sovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("negovf", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

        // Start during RUN is ignored; start held into DONE is accepted there.
        @(negedge clk);
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        check("ign_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        a = 16'hAAAA; b = 16'h5555;
        wait_done(n);
        check("ign_lat", n, 32'd4);
        check("ign_sum", {16'd0, sum}, 32'h2345);
        check("ign_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        a = 16'h0F0F; b = 16'h00F1;
        @(posedge clk);
        #1;
        check("b2b_busy", {31'd0, busy}, 32'd1);
        check("b2b_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        check("b2b_lat", n, 32'd4);
        check("b2b_sum", {16'd0, sum}, 32'h1000);
        check("b2b_cout", {31'd0, cout}, 32'd0);

        // Reset in the second RUN cycle aborts the operation.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0001; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_sum", {16'd0, sum}, 32'h0000);
        check("abort_cout", {31'd0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_done(n);
        check("abort_nodone", n, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
